// File: rtl/lstm_pkg.sv
// Shared constants and types for the LSTM multiplier-array datapath.
// The scheduler and its tag pipeline both take their defaults from here.
package lstm_pkg;

  localparam int LANES    = 16;
  localparam int RD_LAT   = 1;
  localparam int MULT_LAT = 3;
  localparam int ADDR_W   = 10;
  localparam int LEN_W    = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} sched_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_tag_t;

endpackage

// File: rtl/sched_tag_pipe.sv
// Delay line of beat tags that tracks operand-read plus multiplier latency,
// so each tag leaves exactly when its product leaves the multiplier array.
module sched_tag_pipe
  import lstm_pkg::*;
#(
  parameter int DEPTH = RD_LAT + MULT_LAT
) (
  input  logic      clk,
  input  logic      rst,
  input  beat_tag_t in_tag,
  output beat_tag_t out_tag,
  output logic      busy
);

  beat_tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= {stage_q[DEPTH-2:0], in_tag};
  end

  // busy ignores the output stage: a beat sitting there is already visible,
  // which lets the scheduler reach FIN the cycle after the final product.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) busy = busy | stage_q[i].valid;
    out_tag.valid = stage_q[DEPTH-1].valid;
    out_tag.first = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].first;
    out_tag.last  = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].last;
  end

endmodule

// File: rtl/mult_array_sched.sv
// Operand-read scheduler for the multiplier array: walks rows x chunks,
// issues buffer reads and tags each product beat for the adder tree.
module mult_array_sched
  import lstm_pkg::*;
#(
  parameter int RD_LAT   = lstm_pkg::RD_LAT,
  parameter int MULT_LAT = lstm_pkg::MULT_LAT,
  parameter int ADDR_W   = lstm_pkg::ADDR_W,
  parameter int LEN_W    = lstm_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  input  logic [LEN_W-1:0]  rows,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  output logic              prod_valid,
  output logic              prod_first,
  output logic              prod_last,
  output logic              done
);

  sched_state_t      state_q, state_d;
  logic [LEN_W-1:0]  rows_q, len_q, row_q, chunk_q;
  logic [ADDR_W-1:0] x_base_q, w_addr_q, x_addr_q;
  logic              row_end, pipe_busy;
  beat_tag_t         issue_tag, out_tag;

  assign row_end = (chunk_q == len_q - LEN_W'(1));
  assign w_addr  = w_addr_q;
  assign x_addr  = x_addr_q;

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    rd_en     = 1'b0;
    done      = 1'b0;
    issue_tag = '0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = (rows == '0 || vec_len == '0) ? FIN : ISSUE;
      end
      ISSUE: begin
        rd_en           = !hold;
        issue_tag.valid = rd_en;
        issue_tag.first = rd_en && (chunk_q == '0);
        issue_tag.last  = rd_en && row_end;
        if (rd_en && row_end && row_q == rows_q - LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pipe_busy) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The weight address simply counts up (row-major is contiguous); the x
  // address rewinds to x_base at the end of every row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rows_q   <= '0;
      len_q    <= '0;
      row_q    <= '0;
      chunk_q  <= '0;
      x_base_q <= '0;
      w_addr_q <= '0;
      x_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        rows_q   <= rows;
        len_q    <= vec_len;
        x_base_q <= x_base;
        w_addr_q <= w_base;
        x_addr_q <= x_base;
        row_q    <= '0;
        chunk_q  <= '0;
      end else if (rd_en) begin
        w_addr_q <= w_addr_q + ADDR_W'(1);
        if (row_end) begin
          chunk_q  <= '0;
          row_q    <= row_q + LEN_W'(1);
          x_addr_q <= x_base_q;
        end else begin
          chunk_q  <= chunk_q + LEN_W'(1);
          x_addr_q <= x_addr_q + ADDR_W'(1);
        end
      end
    end
  end

  sched_tag_pipe #(
    .DEPTH(RD_LAT + MULT_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .in_tag (issue_tag),
    .out_tag(out_tag),
    .busy   (pipe_busy)
  );

  assign prod_valid = out_tag.valid;
  assign prod_first = out_tag.first;
  assign prod_last  = out_tag.last;

endmodule
